// File: rtl/ldpc_shift_scheduler_if.sv
// ldpc_shift_scheduler_if
//   Bundles the controller handshake, the entry-ROM read port, the barrel
//   shifter control port and the row/col tag stream of the shift scheduler.
//   slave  : the scheduler side (config and ROM data in, control out)
//   master : the surrounding logic (controller, ROM, shifter, consumer)
interface ldpc_shift_scheduler_if #(
    parameter int SHIFT_BITS = 9,
    parameter int ROW_BITS   = 6,
    parameter int COL_BITS   = 7,
    parameter int ENT_BITS   = 10
);
    logic                                   start;
    logic [SHIFT_BITS-1:0]                  z_size;
    logic [ENT_BITS-1:0]                    num_entries;
    logic                                   dir_cfg;
    logic                                   busy;
    logic                                   done;
    logic                                   cfg_err;
    logic                                   ent_rd_en;
    logic [ENT_BITS-1:0]                    ent_rd_addr;
    logic [ROW_BITS+COL_BITS+SHIFT_BITS-1:0] ent_rd_data;
    logic                                   cons_ready;
    logic                                   bs_enable;
    logic [SHIFT_BITS-1:0]                  bs_shift_amount;
    logic [SHIFT_BITS-1:0]                  bs_vector_size;
    logic                                   bs_shift_dir;
    logic                                   bs_issue;
    logic                                   tag_valid;
    logic [ROW_BITS-1:0]                    tag_row;
    logic [COL_BITS-1:0]                    tag_col;
    logic                                   tag_last;

    modport slave (
        input  start, z_size, num_entries, dir_cfg, ent_rd_data, cons_ready,
        output busy, done, cfg_err, ent_rd_en, ent_rd_addr,
               bs_enable, bs_shift_amount, bs_vector_size, bs_shift_dir, bs_issue,
               tag_valid, tag_row, tag_col, tag_last
    );

    modport master (
        output start, z_size, num_entries, dir_cfg, ent_rd_data, cons_ready,
        input  busy, done, cfg_err, ent_rd_en, ent_rd_addr,
               bs_enable, bs_shift_amount, bs_vector_size, bs_shift_dir, bs_issue,
               tag_valid, tag_row, tag_col, tag_last
    );
endinterface

// File: rtl/ldpc_shift_scheduler.sv
// ldpc_shift_scheduler
//   Walks the base-graph entry list, reduces each raw shift V to V mod Z with
//   a restoring remainder loop and issues one shift per entry to the barrel
//   shifter. A row/col/last tag rides a delay line matched to the shifter
//   latency so the consumer knows which block each shifted vector is.
//   Ports: clk, rst_n (async, active low), bus (slave modport): start/config
//   in, busy/done/cfg_err out, entry ROM read port, shifter control, tag out.
module ldpc_shift_scheduler #(
    parameter int SHIFT_BITS = 9,
    parameter int Z_MAX      = 384,
    parameter int ROW_BITS   = 6,
    parameter int COL_BITS   = 7,
    parameter int ENT_BITS   = 10,
    parameter int BS_LAT     = 3
) (
    input logic                    clk,
    input logic                    rst_n,
    ldpc_shift_scheduler_if.slave  bus
);
    localparam int KW    = $clog2(SHIFT_BITS);
    localparam int WW    = 2 * SHIFT_BITS;
    localparam int TAG_W = ROW_BITS + COL_BITS + 2;
    localparam int DW    = $clog2(BS_LAT + 1);
    localparam logic [SHIFT_BITS-1:0] ZMAX_V = SHIFT_BITS'(Z_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_REDUCE, S_ISSUE, S_DRAIN, S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [SHIFT_BITS-1:0]  z_q, z_d, rem_q, rem_d;
    logic [ENT_BITS-1:0]    num_q, num_d, cnt_q, cnt_d;
    logic [ROW_BITS-1:0]    row_q, row_d;
    logic [COL_BITS-1:0]    col_q, col_d;
    logic [KW-1:0]          k_q, k_d;
    logic [DW-1:0]          drn_q, drn_d;
    logic                   dir_q, dir_d, err_q, err_d, en_q, en_d;
    logic [BS_LAT-1:0][TAG_W-1:0] tag_q, tag_d;

    logic                   rd_en, issue, last_ent, bs_en, cfg_bad;
    logic [WW-1:0]          zk;
    logic [SHIFT_BITS-1:0]  rem_sub;

    assign last_ent = (cnt_q == num_q - ENT_BITS'(1));
    assign cfg_bad  = (bus.z_size == '0) || (bus.z_size > ZMAX_V) || (bus.num_entries == '0);

    // en_q remembers that this pass has issued at least once; from then on the
    // shifter runs every cycle (bubbles included) until DRAIN exits.
    assign bs_en = (state_q == S_ISSUE) ||
                   (en_q && (state_q inside {S_FETCH, S_WAIT, S_REDUCE, S_DRAIN}));

    always_comb begin
        state_d = state_q;
        z_d     = z_q;
        num_d   = num_q;
        dir_d   = dir_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        rem_d   = rem_q;
        k_d     = k_q;
        en_d    = en_q;
        drn_d   = drn_q;
        rd_en   = 1'b0;
        issue   = 1'b0;
        // One restoring step: take Z<<k off the remainder if it fits.
        zk      = WW'(z_q) << k_q;
        rem_sub = (zk <= WW'(rem_q)) ? rem_q - zk[SHIFT_BITS-1:0] : rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    en_d = 1'b0;
                    if (cfg_bad) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        z_d     = bus.z_size;
                        num_d   = bus.num_entries;
                        dir_d   = bus.dir_cfg;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                rd_en   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                {row_d, col_d, rem_d} = bus.ent_rd_data;
                k_d     = KW'(SHIFT_BITS - 1);
                state_d = S_REDUCE;
            end
            S_REDUCE: begin
                // Leave as soon as the remainder is below Z, checking the
                // post-subtract value so the worst case stays SHIFT_BITS cycles.
                if (rem_q < z_q) begin
                    state_d = S_ISSUE;
                end else begin
                    rem_d = rem_sub;
                    k_d   = k_q - KW'(1);
                    if (rem_sub < z_q) state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                en_d = 1'b1;
                if (bus.cons_ready) begin
                    issue = 1'b1;
                    if (last_ent) begin
                        drn_d   = DW'(BS_LAT - 1);
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d   = cnt_q + ENT_BITS'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DRAIN: begin
                if (drn_q == '0) state_d = S_DONE;
                else             drn_d   = drn_q - DW'(1);
            end
            S_DONE: begin
                en_d    = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Tag delay line; advances in lock-step with the shifter pipe.
    always_comb begin
        tag_d = tag_q;
        if (bs_en) begin
            tag_d[0] = issue ? {1'b1, row_q, col_q, last_ent} : '0;
            for (int i = 1; i < BS_LAT; i++) tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            z_q     <= '0;
            num_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            rem_q   <= '0;
            k_q     <= '0;
            en_q    <= 1'b0;
            drn_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            num_q   <= num_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            rem_q   <= rem_d;
            k_q     <= k_d;
            en_q    <= en_d;
            drn_q   <= drn_d;
            tag_q   <= tag_d;
        end
    end

    assign bus.busy            = (state_q != S_IDLE);
    assign bus.done            = (state_q == S_DONE);
    assign bus.cfg_err         = err_q;
    assign bus.ent_rd_en       = rd_en;
    assign bus.ent_rd_addr     = rd_en ? cnt_q : '0;
    assign bus.bs_enable       = bs_en;
    assign bus.bs_shift_amount = (state_q == S_ISSUE) ? rem_q : '0;
    assign bus.bs_vector_size  = z_q;
    assign bus.bs_shift_dir    = dir_q;
    assign bus.bs_issue        = issue;
    assign {bus.tag_valid, bus.tag_row, bus.tag_col, bus.tag_last} = tag_q[BS_LAT-1];
endmodule

// File: tb/tb_ldpc_shift_scheduler.sv
module tb_ldpc_shift_scheduler;
    localparam int SB = 9, RB = 6, CB = 7, EB = 10, LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ldpc_shift_scheduler_if #(.SHIFT_BITS(SB), .ROW_BITS(RB), .COL_BITS(CB), .ENT_BITS(EB)) bus();

    ldpc_shift_scheduler #(
        .SHIFT_BITS(SB), .Z_MAX(384), .ROW_BITS(RB), .COL_BITS(CB), .ENT_BITS(EB), .BS_LAT(LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errs = 0, checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // current pass as the reference sees it
    int pz, pn;
    bit pdir;
    int pv[16], pr[16], pc[16];

    // entry ROM: data valid one cycle after the read strobe
    always @(posedge clk)
        if (bus.ent_rd_en)
            bus.ent_rd_data <= {RB'(pr[bus.ent_rd_addr[3:0]]), CB'(pc[bus.ent_rd_addr[3:0]]),
                                SB'(pv[bus.ent_rd_addr[3:0]])};

    // consumer ready: 0 = hold low, 1 = hold high, 2 = random
    int rdy_mode = 1;
    always @(posedge clk) begin
        #2;
        bus.cons_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end

    // scoreboard: expected issues in entry order, expected tags by due cycle
    typedef struct { int row; int col; int last; int due; } tag_t;
    tag_t tq[$];
    int cyc = 0, ii = 0, done_cnt = 0, rd_cnt = 0;
    bit mon_en = 0, exp_v;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (mon_en) begin
        if (bus.done) done_cnt++;
        if (bus.ent_rd_en) begin
            rd_cnt++;
            chk("rd_addr", bus.ent_rd_addr, ii);
        end
        if (bus.bs_issue) begin
            if (ii < pn) begin
                chk("shift_amt", bus.bs_shift_amount, pv[ii] % pz);
                chk("amt_lt_z", bus.bs_shift_amount < bus.bs_vector_size, 1);
                chk("vec_size", bus.bs_vector_size, pz);
                chk("dir", bus.bs_shift_dir, pdir);
                chk("en_on_issue", bus.bs_enable, 1);
                tq.push_back('{pr[ii], pc[ii], int'(ii == pn - 1), cyc + LAT});
            end else begin
                chk("extra_issue", ii, pn - 1);
            end
            ii++;
        end
        while (tq.size() > 0 && tq[0].due < cyc) void'(tq.pop_front());
        exp_v = (tq.size() > 0) && (tq[0].due == cyc);
        chk("tag_valid", bus.tag_valid, exp_v);
        if (exp_v) begin
            chk("tag_row", bus.tag_row, tq[0].row);
            chk("tag_col", bus.tag_col, tq[0].col);
            chk("tag_last", bus.tag_last, tq[0].last);
            void'(tq.pop_front());
        end
    end

    function automatic logic [63:0] all_outs();
        return {bus.busy, bus.done, bus.cfg_err, bus.ent_rd_en, bus.ent_rd_addr, bus.bs_enable,
                bus.bs_shift_amount, bus.bs_vector_size, bus.bs_shift_dir, bus.bs_issue,
                bus.tag_valid, bus.tag_row, bus.tag_col, bus.tag_last};
    endfunction

    task automatic load(input int i, input int r, input int c, input int v);
        pr[i] = r; pc[i] = c; pv[i] = v;
    endtask

    task automatic pulse_start(input int z, input int n, input bit dir);
        ii = 0; rd_cnt = 0; done_cnt = 0; tq.delete();
        @(posedge clk); #1;
        bus.start = 1'b1; bus.z_size = SB'(z); bus.num_entries = EB'(n); bus.dir_cfg = dir;
        @(posedge clk); #1;
        bus.start = 1'b0;
        // config wiggling while busy must not matter
        bus.z_size = SB'($urandom); bus.num_entries = EB'($urandom); bus.dir_cfg = 1'($urandom);
    endtask

    task automatic start_pass(input int z, input int n, input bit dir);
        pz = z; pn = n; pdir = dir;
        pulse_start(z, n, dir);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done) begin ok = 1; break; end
        end
    endtask

    task automatic finish_pass(input string nm);
        bit ok;
        wait_done(3000, ok);
        chk({nm, "_done_seen"}, ok, 1);
        @(negedge clk);
        chk({nm, "_busy_low"}, bus.busy, 0);
        chk({nm, "_done_once"}, done_cnt, 1);
        chk({nm, "_issues"}, ii, pn);
        chk({nm, "_tags_left"}, tq.size(), 0);
        chk({nm, "_cfg_err"}, bus.cfg_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int z, n;
        bus.start = 0; bus.z_size = 0; bus.num_entries = 0; bus.dir_cfg = 0;
        for (int i = 0; i < 16; i++) load(i, 0, 0, 0);

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", all_outs(), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        mon_en = 1;

        // Z=384, V in {0,100,383}
        rdy_mode = 1;
        load(0, 1, 10, 0); load(1, 2, 20, 100); load(2, 3, 30, 383);
        start_pass(384, 3, 1'b1);
        finish_pass("z384");

        // Z=52: 307 -> 47, 52 -> 0
        load(0, 5, 7, 307); load(1, 6, 8, 52);
        start_pass(52, 2, 1'b0);
        finish_pass("z52");

        // consumer stall during ISSUE
        rdy_mode = 0;
        load(0, 9, 3, 250); load(1, 4, 66, 7);
        start_pass(100, 2, 1'b1);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.bs_enable) begin ok = 1; break; end
        end
        chk("stall_reached_issue", ok, 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_no_issue", bus.bs_issue, 0);
            chk("stall_en", bus.bs_enable, 1);
            chk("stall_tag_valid", bus.tag_valid, 0);
        end
        @(posedge clk); #1 rdy_mode = 1;
        finish_pass("stall");

        // bad configurations
        for (int t = 0; t < 3; t++) begin
            pz = 0; pn = 0;
            case (t)
                0: pulse_start(0, 1, 1'b0);
                1: pulse_start(400, 1, 1'b0);
                default: pulse_start(10, 0, 1'b0);
            endcase
            @(negedge clk);
            chk("cfg_done_pulse", bus.done, 1);
            chk("cfg_err_set", bus.cfg_err, 1);
            @(negedge clk);
            chk("cfg_done_low", bus.done, 0);
            chk("cfg_busy_low", bus.busy, 0);
            chk("cfg_no_reads", rd_cnt, 0);
            chk("cfg_no_issue", ii, 0);
        end
        load(0, 11, 12, 13);
        start_pass(200, 1, 1'b0);
        @(negedge clk);
        chk("cfg_err_cleared", bus.cfg_err, 0);
        finish_pass("cfg_recover");

        // reset while entry 2 of 4 is reducing
        load(0, 1, 1, 10); load(1, 2, 2, 3); load(2, 3, 3, 511); load(3, 4, 4, 20);
        start_pass(5, 4, 1'b1);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.ent_rd_en && bus.ent_rd_addr == 2) begin ok = 1; break; end
        end
        chk("rst_fetch2_seen", ok, 1);
        @(negedge clk); @(negedge clk);
        #1 rst_n = 1'b0; mon_en = 0;
        #1 chk("rst_async_outs", all_outs(), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_done", bus.done, 0);
        end
        @(posedge clk); #1 rst_n = 1'b1; mon_en = 1;
        start_pass(5, 4, 1'b1);
        finish_pass("replay");

        // start during DRAIN with different config
        load(0, 7, 70, 383); load(1, 8, 80, 384);
        start_pass(384, 2, 1'b1);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ii >= 2) begin ok = 1; break; end
        end
        chk("drain_reached", ok, 1);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.dir_cfg = 1'b0; bus.z_size = 10; bus.num_entries = 3;
        @(posedge clk); #1 bus.start = 1'b0;
        finish_pass("drain_start");
        chk("drain_dir_kept", bus.bs_shift_dir, 1);
        repeat (6) @(negedge clk);
        chk("drain_no_second_done", done_cnt, 1);
        chk("drain_idle", bus.busy, 0);

        // randomized passes with a random consumer
        rdy_mode = 2;
        for (int p = 0; p < 10; p++) begin
            z = (p == 0) ? 1 : (p == 1) ? 384 : $urandom_range(1, 384);
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++)
                load(i, $urandom_range(0, 63), $urandom_range(0, 127),
                     (i == 0) ? z : $urandom_range(0, 511));
            start_pass(z, n, 1'($urandom));
            finish_pass("rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/ldpc_shift_scheduler.md
Name: ldpc_shift_scheduler

Overview:
- Sequencer for the QC-LDPC cyclic shift datapath.
- Walks a base-graph entry list of (row, col, raw shift V), reduces each V to V mod Z and issues one shift per entry to the 3-stage programmable barrel shifter.
- Carries a row/col/last tag through a delay line matched to the shifter latency, so the CN/VN consumer knows which block each shifted vector belongs to.
- Sits between the decoder top-level controller, the base-graph entry ROM and the shifter.

Parameters:
- SHIFT_BITS, 9, width of Z and shift values (Z_MAX=384).
- Z_MAX, 384, maximum legal lifting factor.
- ROW_BITS, 6, base-graph row index width.
- COL_BITS, 7, base-graph column index width.
- ENT_BITS, 10, entry-list address width.
- BS_LAT, 3, shifter latency in enabled cycles.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin a pass; ignored unless IDLE
- z_size  in  SHIFT_BITS  lifting factor Z; latched on start
- num_entries  in  ENT_BITS  entry count; latched on start
- dir_cfg  in  1  shift direction, 1=left (gather), 0=right (scatter); latched on start
- busy  out  1  high from accepted start until DONE exits
- done  out  1  one-cycle pass-complete pulse
- cfg_err  out  1  sticky config error; cleared by next accepted start
- ent_rd_en  out  1  entry ROM read strobe
- ent_rd_addr  out  ENT_BITS  entry ROM address
- ent_rd_data  in  ROW_BITS+COL_BITS+SHIFT_BITS  {row, col, V}; valid exactly 1 cycle after ent_rd_en
- cons_ready  in  1  consumer can accept a vector BS_LAT cycles later
- bs_enable  out  1  shifter enable
- bs_shift_amount  out  SHIFT_BITS  reduced shift V mod Z
- bs_vector_size  out  SHIFT_BITS  latched Z
- bs_shift_dir  out  1  latched dir_cfg
- bs_issue  out  1  high on cycles whose shifter input is a real vector
- tag_valid  out  1  shifter data_out is a real vector this cycle
- tag_row  out  ROW_BITS  row of that vector
- tag_col  out  COL_BITS  col of that vector
- tag_last  out  1  vector is the final entry of the pass

Behaviour:
- Reset values: all outputs 0, state IDLE, tag pipe cleared. Reset mid-pass aborts immediately; no done pulse.
- States: IDLE, FETCH, WAIT, REDUCE, ISSUE, DRAIN, DONE.
- IDLE + start:
  - If z_size==0, z_size>Z_MAX or num_entries==0: set cfg_err and go to DONE (done pulses, no shifts issued).
  - Otherwise latch config, clear cfg_err and the entry counter, go to FETCH.
- FETCH: ent_rd_en=1, ent_rd_addr=counter; next WAIT.
- WAIT: capture ent_rd_data into row/col/rem registers; next REDUCE.
- REDUCE (restoring remainder):
  - Each cycle, subtract the largest Z<<k (k=SHIFT_BITS-1..0, descending) that is <= rem, one k per cycle.
  - When rem<Z, go to ISSUE immediately, including on the first cycle.
  - Worst case SHIFT_BITS cycles per entry.
- ISSUE:
  - Hold bs_shift_amount=rem; wait for cons_ready.
  - On the cycle cons_ready=1: bs_issue=1; push {1,row,col,last} into the tag pipe, with last = (counter==num_entries-1).
  - Then if last go to DRAIN, else increment counter and go to FETCH.
- bs_enable:
  - Asserted every cycle from the first ISSUE cycle of a pass until DRAIN exits. The shifter pipe advances every cycle, so tags stay aligned.
  - Shifter valid_out is unreliable during bubbles; consumers use tag_valid only.
- Tag pipe:
  - BS_LAT-deep shift register, advanced whenever bs_enable=1.
  - Non-issue cycles push tag_valid=0.
  - A tag issued at cycle t appears on tag_* at cycle t+BS_LAT.
- DRAIN: keep bs_enable=1 until the last tag exits (BS_LAT cycles after the last issue); next DONE.
- DONE: done=1 for one cycle, bs_enable=0; next IDLE. busy drops the cycle after DONE.
- start while busy is ignored; configuration changes while busy are ignored.
- bs_shift_amount < bs_vector_size whenever bs_issue=1 (invariant for the bench to assert).
- V values of 0 or exactly Z reduce to 0; V < Z passes through unchanged.

Test Plan:
- Z=384, 3 entries V={0,100,383}, cons_ready=1 → bs_shift_amount 0,100,383; tags (row,col) in order at issue+3; tag_last on 3rd; one done pulse.
- Z=52, entry V=307 → REDUCE yields 47 (307-208-52); bs_issue with amount 47; V=52 → 0.
- cons_ready low 5 cycles during ISSUE → no bs_issue and tag_valid=0 bubbles, bs_enable stays 1; the issue proceeds when ready rises.
- start with z_size=0, then z_size=400, then num_entries=0 → cfg_err=1, done after 1 cycle, ent_rd_en never asserted; next valid start clears cfg_err.
- rst_n asserted while entry 2 of 4 is in REDUCE → all outputs 0 asynchronously; no done; a fresh start replays from entry 0.
- start pulsed during DRAIN with a different dir_cfg → ignored; bs_shift_dir unchanged; exactly one done.
